mult_shift_add_unit: RTL and testbench

//  - Sequential shift-add multiplier for the MIPS MULT/MULTU path.
//  - Performs one add-and-shift iteration per clock.
//  - Upstream: the ID/EX operand registers drive A, B, Signed and Start.
//  - Downstream: the Hi/Lo register pair captures Hi/Lo when Done pulses.
//  - Hi/Lo are built from enable-gated D flip-flops.

---
 rtl/mult_shift_add_unit_pkg.sv | 19 +
 rtl/mult_shift_add_unit_product_reg.sv | 50 +++++
 rtl/mult_shift_add_unit.sv | 120 ++++++++++++
 tb/tb_mult_shift_add_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_shift_add_unit_pkg.sv
// Shared definitions for the shift-add multiplier: state encoding, default width
// and the iteration-counter sizing helper.
package mult_shift_add_unit_pkg;

  localparam int MULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // The counter must be able to represent WIDTH itself.
  function automatic int cntWidth(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mult_shift_add_unit_product_reg.sv
// 2*WIDTH+1-bit product register for the shift-add multiplier: parallel load,
// one add-and-shift step, and two's-complement negation of the low 2*WIDTH bits.
module mult_shift_add_unit_product_reg #(
  parameter int WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               clrN_i,
  input  logic               load_i,
  input  logic               shiftAdd_i,
  input  logic               negate_i,
  input  logic [2*WIDTH:0]   loadVal_i,
  input  logic [WIDTH:0]     mcand_i,
  output logic [2*WIDTH-1:0] result_o
);

  logic [2*WIDTH:0] prod_q;
  logic [2*WIDTH:0] prod_d;
  logic [WIDTH+1:0] upperSum;

  // The upper part is WIDTH+1 bits; one extra bit keeps the carry before the shift.
  always_comb begin
    upperSum = {1'b0, prod_q[2*WIDTH:WIDTH]};
    if (prod_q[0]) begin
      upperSum = {1'b0, prod_q[2*WIDTH:WIDTH]} + {1'b0, mcand_i};
    end
  end

  always_comb begin
    prod_d = prod_q;
    if (load_i) begin
      prod_d = loadVal_i;
    end else if (shiftAdd_i) begin
      prod_d = {upperSum, prod_q[WIDTH-1:1]};
    end else if (negate_i) begin
      prod_d = {prod_q[2*WIDTH], -prod_q[2*WIDTH-1:0]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clrN_i) begin
      prod_q <= '0;
    end else begin
      prod_q <= prod_d;
    end
  end

  // Exposes the value being written so the top can capture Hi/Lo on the same edge.
  assign result_o = prod_d[2*WIDTH-1:0];

endmodule

// File: rtl/mult_shift_add_unit.sv
// Sequential shift-add multiplier for MULT/MULTU: one add-and-shift per clock,
// sign fix-up cycle, then a one-cycle Done pulse with Hi/Lo valid.
module mult_shift_add_unit
  import mult_shift_add_unit_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CntW = cntWidth(WIDTH);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]    mcand_q, mcand_d;
  logic              neg_q, neg_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;

  logic              prodLoad;
  logic              prodShiftAdd;
  logic              prodNegate;
  logic [WIDTH-1:0]  absA;
  logic [WIDTH-1:0]  absB;
  logic [2*WIDTH:0]  prodLoadVal;
  logic [2*WIDTH-1:0] prodResult;

  // Magnitudes stay exact for the most negative value once zero-extended by one bit.
  assign absA = (Signed && A[WIDTH-1]) ? -A : A;
  assign absB = (Signed && B[WIDTH-1]) ? -B : B;
  assign prodLoadVal = {{(WIDTH+1){1'b0}}, absB};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mcand_d      = mcand_q;
    neg_d        = neg_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    prodLoad     = 1'b0;
    prodShiftAdd = 1'b0;
    prodNegate   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          prodLoad = 1'b1;
          mcand_d  = {1'b0, absA};
          neg_d    = Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        prodShiftAdd = 1'b1;
        cnt_d        = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        prodNegate = neg_q;
        hi_d       = prodResult[2*WIDTH-1:WIDTH];
        lo_d       = prodResult[WIDTH-1:0];
        state_d    = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  mult_shift_add_unit_product_reg #(
    .WIDTH(WIDTH)
  ) uProductReg (
    .clk_i      (Clk),
    .clrN_i     (Reset_n),
    .load_i     (prodLoad),
    .shiftAdd_i (prodShiftAdd),
    .negate_i   (prodNegate),
    .loadVal_i  (prodLoadVal),
    .mcand_i    (mcand_q),
    .result_o   (prodResult)
  );

  assign Busy = (state_q != IDLE);
  assign Done = (state_q == DONE);
  assign Hi   = hi_q;
  assign Lo   = lo_q;

endmodule

// File: tb/tb_mult_shift_add_unit.sv
// Self-checking bench for mult_shift_add_unit: directed corner cases plus random
// operands compared against a plain 64-bit arithmetic reference.
module tb_mult_shift_add_unit;

  logic        Clk;
  logic        Reset_n;
  logic        Start;
  logic        Signed;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Done;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int total = 0;
  int bad   = 0;
  logic [63:0] lastExp;

  mult_shift_add_unit #(.WIDTH(32)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Start   (Start),
    .Signed  (Signed),
    .A       (A),
    .B       (B),
    .Busy    (Busy),
    .Done    (Done),
    .Hi      (Hi),
    .Lo      (Lo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [63:0] refProduct(input logic s, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa;
    longint sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    Start  = 1'b1;
    Signed = s;
    A      = a;
    B      = b;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    A     = $urandom;
    B     = $urandom;
  endtask

  task automatic runOp(input string tag, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic pokeInDone);
    int cycles;
    logic [63:0] expProd;
    expProd = refProduct(s, a, b);
    applyStimulus(s, a, b);
    checkOutput({tag, "_busyAfterAccept"}, 64'(Busy), 64'd1);
    cycles = 0;
    while (Done !== 1'b1 && cycles < 100) begin
      @(posedge Clk);
      #1;
      cycles++;
    end
    checkOutput({tag, "_latency"}, 64'(cycles), 64'd33);
    checkOutput({tag, "_product"}, {Hi, Lo}, expProd);
    checkOutput({tag, "_busyInDone"}, 64'(Busy), 64'd1);
    if (pokeInDone) begin
      Start  = 1'b1;
      Signed = 1'b0;
      A      = $urandom;
      B      = $urandom;
    end
    @(posedge Clk);
    #1;
    Start = 1'b0;
    checkOutput({tag, "_doneOneCycle"}, 64'(Done), 64'd0);
    checkOutput({tag, "_idleBusy"}, 64'(Busy), 64'd0);
    lastExp = expProd;
  endtask

  initial begin
    int doneCnt;
    int busyErr;
    logic [63:0] got;
    logic [63:0] expProd;
    logic [31:0] a0;
    logic [31:0] b0;

    Reset_n = 1'b0;
    Start   = 1'b0;
    Signed  = 1'b0;
    A       = '0;
    B       = '0;
    lastExp = '0;
    repeat (3) @(posedge Clk);
    #1;
    checkOutput("reset_busy", 64'(Busy), 64'd0);
    checkOutput("reset_done", 64'(Done), 64'd0);
    checkOutput("reset_hilo", {Hi, Lo}, 64'd0);
    @(negedge Clk);
    Reset_n = 1'b1;

    runOp("multu_3x5", 1'b0, 32'd3, 32'd5, 1'b0);
    runOp("multu_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    runOp("mult_neg3x5", 1'b1, 32'hFFFF_FFFD, 32'd5, 1'b0);
    runOp("mult_minxmin", 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    checkOutput("mult_minxmin_hi", 64'(Hi), 64'h4000_0000);
    runOp("mult_m1xm1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    checkOutput("mult_m1xm1_lo", 64'(Lo), 64'd1);
    runOp("mult_zero", 1'b1, 32'd0, 32'h8000_0000, 1'b0);
    runOp("mult_minxone", 1'b1, 32'h8000_0000, 32'd1, 1'b0);

    runOp("start_in_done", 1'b1, 32'h1234_5678, 32'hFEDC_BA98, 1'b1);
    @(posedge Clk);
    #1;
    checkOutput("start_in_done_ignored", 64'(Busy), 64'd0);
    repeat (5) @(posedge Clk);
    #1;
    checkOutput("hilo_hold", {Hi, Lo}, lastExp);

    for (int i = 0; i < 8; i++) begin
      runOp($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0);
    end

    // Start hammered with new operands while busy: one Done, first operands win.
    a0 = $urandom;
    b0 = $urandom;
    expProd = refProduct(1'b1, a0, b0);
    applyStimulus(1'b1, a0, b0);
    doneCnt = 0;
    busyErr = 0;
    got = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge Clk);
      if (c >= 5 && c <= 20) begin
        Start  = 1'b1;
        Signed = 1'($urandom_range(0, 1));
        A      = $urandom;
        B      = $urandom;
      end else begin
        Start = 1'b0;
      end
      @(posedge Clk);
      #1;
      if (Done === 1'b1) begin
        doneCnt++;
        got = {Hi, Lo};
      end
      if (c <= 33 && Busy !== 1'b1) busyErr++;
    end
    checkOutput("busy_start_doneCount", 64'(doneCnt), 64'd1);
    checkOutput("busy_start_product", got, expProd);
    checkOutput("busy_start_busyHeld", 64'(busyErr), 64'd0);
    checkOutput("busy_start_idleAfter", 64'(Busy), 64'd0);

    // Reset in the middle of an operation abandons it.
    applyStimulus(1'b0, 32'hDEAD_BEEF, 32'h0000_0F0F);
    repeat (9) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b0;
    @(posedge Clk);
    #1;
    checkOutput("midreset_busy", 64'(Busy), 64'd0);
    checkOutput("midreset_done", 64'(Done), 64'd0);
    checkOutput("midreset_hilo", {Hi, Lo}, 64'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    doneCnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge Clk);
      #1;
      if (Done === 1'b1) doneCnt++;
    end
    checkOutput("midreset_noDone", 64'(doneCnt), 64'd0);
    runOp("after_reset", 1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
